// File: rtl/uf_pkg.sv
// Shared definitions for the union-find request scheduler: engine op codes,
// scheduler FSM encoding and the default label width.
package uf_pkg;

  localparam int UF_ADDR_WIDTH = 8;

  localparam logic [1:0] UF_OP_FIND  = 2'b00;
  localparam logic [1:0] UF_OP_UNION = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } uf_state_t;

endpackage

// File: rtl/uf_sched_if.sv
// Request, result and engine-port signals of the union-find scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface uf_sched_if import uf_pkg::*; #(
  parameter int ADDR_WIDTH = UF_ADDR_WIDTH
) ();

  logic                  uq_valid;
  logic                  uq_ready;
  logic [ADDR_WIDTH-1:0] uq_a;
  logic [ADDR_WIDTH-1:0] uq_b;

  logic                  fq_valid;
  logic                  fq_ready;
  logic [ADDR_WIDTH-1:0] fq_node;

  logic                  fr_valid;
  logic [ADDR_WIDTH-1:0] fr_root;

  logic                  uf_start;
  logic [1:0]            uf_op;
  logic [ADDR_WIDTH-1:0] uf_node1;
  logic [ADDR_WIDTH-1:0] uf_node2;
  logic [ADDR_WIDTH-1:0] uf_result;
  logic                  uf_done;

  modport slave (
    input  uq_valid, uq_a, uq_b, fq_valid, fq_node, uf_result, uf_done,
    output uq_ready, fq_ready, fr_valid, fr_root, uf_start, uf_op, uf_node1, uf_node2
  );

  modport master (
    output uq_valid, uq_a, uq_b, fq_valid, fq_node, uf_result, uf_done,
    input  uq_ready, fq_ready, fr_valid, fr_root, uf_start, uf_op, uf_node1, uf_node2
  );

endinterface

// File: rtl/uf_req_fifo.sv
// Synchronous FIFO buffering union requests; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uf_req_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uf_sched.sv
// Serialises buffered unions and relabel finds onto the single union-find
// engine port; every accepted union is merged before a later find is issued.
//
// state   | meaning
// S_IDLE  | nothing in flight; pop a union or accept a find
// S_ISSUE | operands latched, uf_start pulsed this cycle
// S_WAIT  | operands held until the engine signals uf_done
module uf_sched import uf_pkg::*; #(
  parameter int ADDR_WIDTH = UF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  uf_sched_if.slave            bus,
  output logic                 idle,
  output logic [CNT_WIDTH-1:0] union_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  uf_state_t             state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] node1_q, node1_d;
  logic [ADDR_WIDTH-1:0] node2_q, node2_d;
  logic                  fr_valid_q, fr_valid_d;
  logic [ADDR_WIDTH-1:0] fr_root_q, fr_root_d;
  logic                  rdy_q, rdy_d;
  logic [CNT_WIDTH-1:0]  union_cnt_q, union_cnt_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*ADDR_WIDTH-1:0] fifo_rdata;
  logic                    u_accept, u_self;

  // rdy_q keeps both request channels closed until the first edge after reset
  assign bus.uq_ready = rdy_q && !fifo_full;
  assign u_self       = (bus.uq_a == bus.uq_b);
  assign u_accept     = bus.uq_valid && bus.uq_ready;
  assign fifo_push    = u_accept && !u_self;

  // A find may not slip past a real union offered in the same cycle
  assign bus.fq_ready = rdy_q && (state_q == S_IDLE) && fifo_empty
                        && !(bus.uq_valid && !u_self);

  uf_req_fifo #(
    .WIDTH (2*ADDR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (fifo_push),
    .wdata ({bus.uq_a, bus.uq_b}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    node1_d     = node1_q;
    node2_d     = node2_q;
    fr_valid_d  = 1'b0;
    fr_root_d   = fr_root_q;
    rdy_d       = 1'b1;
    union_cnt_d = union_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    fifo_pop    = 1'b0;

    if (u_accept && u_self && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = UF_OP_UNION;
          node1_d  = fifo_rdata[2*ADDR_WIDTH-1:ADDR_WIDTH];
          node2_d  = fifo_rdata[ADDR_WIDTH-1:0];
          state_d  = S_ISSUE;
        end else if (bus.fq_valid && bus.fq_ready) begin
          op_d    = UF_OP_FIND;
          node1_d = bus.fq_node;
          node2_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.uf_done) begin
          state_d = S_IDLE;
          if (op_q == UF_OP_FIND) begin
            fr_valid_d = 1'b1;
            fr_root_d  = bus.uf_result;
          end else if (union_cnt_q != '1) begin
            union_cnt_d = union_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= UF_OP_FIND;
      node1_q     <= '0;
      node2_q     <= '0;
      fr_valid_q  <= 1'b0;
      fr_root_q   <= '0;
      rdy_q       <= 1'b0;
      union_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      node1_q     <= node1_d;
      node2_q     <= node2_d;
      fr_valid_q  <= fr_valid_d;
      fr_root_q   <= fr_root_d;
      rdy_q       <= rdy_d;
      union_cnt_q <= union_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.uf_start = (state_q == S_ISSUE);
  assign bus.uf_op    = op_q;
  assign bus.uf_node1 = node1_q;
  assign bus.uf_node2 = node2_q;
  assign bus.fr_valid = fr_valid_q;
  assign bus.fr_root  = fr_root_q;
  assign idle         = fifo_empty && (state_q == S_IDLE);
  assign union_cnt    = union_cnt_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_uf_sched.sv
// Scoreboard bench for uf_sched: accepted requests predict the engine issue
// order and find roots; an engine model and a result monitor check them.
module tb_uf_sched;

  typedef struct {
    logic [1:0] op;
    logic [7:0] n1;
    logic [7:0] n2;
  } iss_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        idle;
  logic [15:0] union_cnt, drop_cnt;

  uf_sched_if #(.ADDR_WIDTH(8)) bus ();

  uf_sched #(.ADDR_WIDTH(8), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .idle      (idle),
    .union_cnt (union_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc++;

  int   nchecks = 0, nerrors = 0;
  iss_t exp_issue[$];
  logic [7:0] exp_fr[$];
  logic [7:0] par [2][256];   // [0] at acceptance time, [1] inside the engine
  int   exp_union = 0, exp_drop = 0;
  int   find_acc_cyc = 0, done_cyc = 0;
  int   lat_min = 1, lat_max = 1;
  bit   eng_busy = 0, spur_done = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void reset_models();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 256; i++) par[w][i] = 8'(i);
  endfunction

  function automatic logic [7:0] find_root(input int w, input logic [7:0] n);
    logic [7:0] r = n;
    while (par[w][r] != r) r = par[w][r];
    return r;
  endfunction

  // the smaller root label always survives a merge
  function automatic void do_union(input int w, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ra = find_root(w, a);
    logic [7:0] rb = find_root(w, b);
    if (ra < rb) par[w][rb] = ra;
    else if (rb < ra) par[w][ra] = rb;
  endfunction

  task automatic drive(input bit uv, input logic [7:0] a, input logic [7:0] b,
                       input bit fv, input logic [7:0] n, output bit au, output bit af);
    iss_t e;
    @(negedge clk);
    bus.uq_valid = uv; bus.uq_a = a; bus.uq_b = b;
    bus.fq_valid = fv; bus.fq_node = n;
    #1;
    au = uv && bus.uq_ready;
    af = fv && bus.fq_ready;
    if (au) begin
      if (a == b) exp_drop++;
      else begin
        e.op = 2'b01; e.n1 = a; e.n2 = b;
        exp_issue.push_back(e);
        do_union(0, a, b);
        exp_union++;
      end
    end
    if (af) begin
      e.op = 2'b00; e.n1 = n; e.n2 = 8'd0;
      exp_issue.push_back(e);
      exp_fr.push_back(find_root(0, n));
      find_acc_cyc = cyc;
    end
  endtask

  task automatic idle_cycles(input int n);
    bit au, af;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, au, af);
  endtask

  task automatic push_union(input logic [7:0] a, input logic [7:0] b, output int stalls);
    bit au, af;
    int k = 0;
    stalls = 0;
    do begin
      drive(1, a, b, 0, 0, au, af);
      if (!au) stalls++;
      k++;
    end while (!au && k < 200);
    if (!au) chk("union_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int k = 0;
    while (!(idle && exp_issue.size() == 0 && exp_fr.size() == 0 && !eng_busy) && k < 3000) begin
      idle_cycles(1);
      k++;
    end
    chk("drain_done", (k < 3000) ? 1 : 0, 1);
    chk("union_cnt", int'(union_cnt), exp_union);
    chk("drop_cnt", int'(drop_cnt), exp_drop);
  endtask

  // engine model: checks each issue against the scoreboard, holds, then completes
  initial begin
    iss_t e;
    logic [1:0] cop;
    logic [7:0] cn1, cn2;
    int lat;
    bit aborted;
    bus.uf_done = 1'b0;
    bus.uf_result = 8'd0;
    forever begin
      @(negedge clk);
      if (spur_done) begin
        bus.uf_done = 1'b1; bus.uf_result = 8'hA5;
        @(negedge clk);
        bus.uf_done = 1'b0;
        spur_done = 0;
      end else if (reset_n && bus.uf_start) begin
        eng_busy = 1;
        cop = bus.uf_op; cn1 = bus.uf_node1; cn2 = bus.uf_node2;
        if (exp_issue.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          e = exp_issue.pop_front();
          chk("issue_op", int'(cop), int'(e.op));
          chk("issue_node1", int'(cn1), int'(e.n1));
          if (e.op == 2'b01) chk("issue_node2", int'(cn2), int'(e.n2));
          else chk("find_start_latency", cyc, find_acc_cyc + 1);
        end
        lat = $urandom_range(lat_max, lat_min);
        aborted = 0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (!reset_n) begin aborted = 1; break; end
          chk("start_single_pulse", int'(bus.uf_start), 0);
          chk("operands_stable", int'({bus.uf_op, bus.uf_node1, bus.uf_node2}), int'({cop, cn1, cn2}));
        end
        if (!aborted) begin
          if (cop == 2'b00) bus.uf_result = find_root(1, cn1);
          else begin
            bus.uf_result = 8'd0;
            do_union(1, cn1, cn2);
          end
          bus.uf_done = 1'b1;
          done_cyc = cyc;
          @(negedge clk);
          bus.uf_done = 1'b0;
        end
        eng_busy = 0;
      end
    end
  end

  // result monitor
  initial begin
    logic [7:0] r;
    forever begin
      @(negedge clk);
      if (bus.fr_valid) begin
        if (exp_fr.size() == 0) chk("unexpected_fr_valid", 1, 0);
        else begin
          r = exp_fr.pop_front();
          chk("fr_root", int'(bus.fr_root), int'(r));
          chk("fr_latency", cyc, done_cyc + 1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit au, af;
    int stalls, total_stalls, k, lowcyc;
    int uc0, dc0;
    logic [7:0] a8, b8;
    logic [7:0] pairs [6][2] = '{'{1,2}, '{3,4}, '{2,4}, '{5,6}, '{7,8}, '{6,8}};
    reset_models();
    bus.uq_valid = 0; bus.uq_a = 0; bus.uq_b = 0;
    bus.fq_valid = 0; bus.fq_node = 0;

    repeat (3) @(negedge clk);
    chk("rst_uq_ready", int'(bus.uq_ready), 0);
    chk("rst_fq_ready", int'(bus.fq_ready), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_uf_start", int'(bus.uf_start), 0);
    chk("rst_fr_valid", int'(bus.fr_valid), 0);
    chk("rst_fr_root", int'(bus.fr_root), 0);
    chk("rst_union_cnt", int'(union_cnt), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("uq_ready_after_release", int'(bus.uq_ready), 1);

    // single find, engine latency 3
    lat_min = 3; lat_max = 3;
    drive(0, 0, 0, 1, 8'd5, au, af);
    chk("find5_accept", int'(af), 1);
    drain();

    // union burst against a slow engine
    lat_min = 8; lat_max = 8;
    total_stalls = 0;
    for (int i = 0; i < 6; i++) begin
      push_union(pairs[i][0], pairs[i][1], stalls);
      total_stalls += stalls;
    end
    chk("burst_backpressure", (total_stalls > 0) ? 1 : 0, 1);
    drain();
    chk("burst_union_cnt6", int'(union_cnt), 6);

    // self-union dropped
    lat_min = 1; lat_max = 3;
    drive(1, 8'd9, 8'd9, 0, 0, au, af);
    chk("self_union_accept", int'(au), 1);
    for (int i = 0; i < 4; i++) begin
      idle_cycles(1);
      chk("self_union_idle", int'(idle), 1);
    end
    chk("self_union_drop_cnt", int'(drop_cnt), 1);

    // ordering barrier: union (10,11) alongside find 11
    drive(1, 8'd10, 8'd11, 1, 8'd11, au, af);
    chk("order_union_accept", int'(au), 1);
    chk("order_find_blocked", int'(af), 0);
    k = 0; lowcyc = 0;
    do begin
      drive(0, 0, 0, 1, 8'd11, au, af);
      if (!af) lowcyc++;
      k++;
    end while (!af && k < 100);
    chk("order_find_waits", (lowcyc >= 3 && af) ? 1 : 0, 1);
    drain();

    // spurious done while idle
    uc0 = int'(union_cnt); dc0 = int'(drop_cnt);
    spur_done = 1;
    idle_cycles(4);
    chk("spur_idle", int'(idle), 1);
    chk("spur_union_cnt", int'(union_cnt), uc0);
    chk("spur_drop_cnt", int'(drop_cnt), dc0);

    // randomized traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      a8 = 8'($urandom_range(15, 0));
      b8 = 8'($urandom_range(15, 0));
      drive(1'($urandom_range(1, 0)), a8, b8, ($urandom_range(2, 0) == 0),
            8'($urandom_range(15, 0)), au, af);
    end
    drain();

    // reset during S_WAIT with three unions buffered
    lat_min = 40; lat_max = 40;
    push_union(8'd20, 8'd21, stalls);
    push_union(8'd22, 8'd23, stalls);
    push_union(8'd24, 8'd25, stalls);
    push_union(8'd26, 8'd27, stalls);
    idle_cycles(3);
    chk("midop_not_idle", int'(idle), 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_uq_ready", int'(bus.uq_ready), 0);
    chk("async_fq_ready", int'(bus.fq_ready), 0);
    chk("async_uf_start", int'(bus.uf_start), 0);
    chk("async_uf_op", int'(bus.uf_op), 0);
    chk("async_uf_node1", int'(bus.uf_node1), 0);
    chk("async_uf_node2", int'(bus.uf_node2), 0);
    chk("async_idle", int'(idle), 1);
    chk("async_union_cnt", int'(union_cnt), 0);
    chk("async_drop_cnt", int'(drop_cnt), 0);
    exp_issue.delete();
    exp_fr.delete();
    reset_models();
    exp_union = 0; exp_drop = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(20);
    chk("post_reset_idle", int'(idle), 1);
    chk("post_reset_union_cnt", int'(union_cnt), 0);
    chk("post_reset_drop_cnt", int'(drop_cnt), 0);
    chk("post_reset_engine_quiet", int'(eng_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
